// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: divider FSM encodings and default datapath width.
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_PREP = 2'd1;
  localparam div_state_t DIV_RUN  = 2'd2;
  localparam div_state_t DIV_FIX  = 2'd3;

endpackage

// File: rtl/mips_div_iter.sv
// Combinational block of STAGE restoring-division steps on a {remainder, dividend} pair.
module mips_div_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int STAGE = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_shift,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_shift
);

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ok;

  always_comb begin
    // NOTE: every variable is given a value before the loop, so no latch is inferred.
    w_rem   = i_rem;
    w_shift = i_shift;
    w_sh    = '0;
    w_diff  = '0;
    w_ok    = 1'b0;
    for (int i = 0; i < STAGE; i++) begin
      w_sh    = {w_rem, w_shift[WIDTH-1]};
      w_diff  = {1'b0, w_sh} - {2'b00, i_div};
      // The two top bits are both zero exactly when the trial subtraction did not borrow.
      w_ok    = (w_diff[WIDTH+1:WIDTH] == 2'b00);
      w_rem   = w_ok ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
      w_shift = {w_shift[WIDTH-2:0], w_ok};
    end
  end

  assign o_rem   = w_rem;
  assign o_shift = w_shift;

endmodule

// File: rtl/mips_div_seq.sv
// Multicycle signed/unsigned iterative divider producing LO (quotient) and HI (remainder).
module mips_div_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int STAGE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int N  = WIDTH / STAGE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_shift, r_div;
  logic             r_sgn, r_q_neg, r_r_neg, r_zero;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_nx, w_shift_nx, w_q_fix, w_r_fix;

  assign w_a_neg = r_sgn & r_a[WIDTH-1];
  assign w_b_neg = r_sgn & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;

  // A zero divisor reports all-ones and hands back the original dividend untouched.
  assign w_q_fix = r_zero ? '1  : (r_q_neg ? -r_shift : r_shift);
  assign w_r_fix = r_zero ? r_a : (r_r_neg ? -r_rem   : r_rem);

  mips_div_iter #(
    .WIDTH (WIDTH),
    .STAGE (STAGE)
  ) u_iter (
    .i_rem   (r_rem),
    .i_shift (r_shift),
    .i_div   (r_div),
    .o_rem   (w_rem_nx),
    .o_shift (w_shift_nx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_shift   <= '0;
      r_div     <= '0;
      r_sgn     <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_zero    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state <= DIV_IDLE;
        r_cnt   <= '0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          DIV_IDLE: begin
            if (start) begin
              r_a     <= a;
              r_b     <= b;
              r_sgn   <= signed_op;
              busy    <= 1'b1;
              r_state <= DIV_PREP;
            end
          end
          DIV_PREP: begin
            r_rem   <= '0;
            r_shift <= w_a_mag;
            r_div   <= w_b_mag;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_zero  <= (r_b == '0);
            r_cnt   <= '0;
            r_state <= DIV_RUN;
          end
          DIV_RUN: begin
            r_rem   <= w_rem_nx;
            r_shift <= w_shift_nx;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= DIV_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DIV_FIX: begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
            div_zero  <= r_zero;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= DIV_IDLE;
          end
          default: r_state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_div_seq.sv
// Bench for mips_div_seq: directed corner cases on a 32/4 instance plus a parallel parameter sweep.
module tb_mips_div_seq;

  localparam int NI = 6;

  function automatic int cfg_w(input int k);
    return (k == 5) ? 16 : 32;
  endfunction

  function automatic int cfg_s(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      4: return 32;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [NI];
  logic        sop_s   [NI];
  logic        abort_s [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];
  logic        dz_s    [NI];
  logic [31:0] a_s     [NI];
  logic [31:0] b_s     [NI];
  logic [31:0] q_s     [NI];
  logic [31:0] r_s     [NI];

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int W = cfg_w(k);
    localparam int S = cfg_s(k);
    logic [W-1:0] w_q, w_r;

    mips_div_seq #(
      .WIDTH (W),
      .STAGE (S)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[k]),
      .signed_op (sop_s[k]),
      .abort     (abort_s[k]),
      .a         (a_s[k][W-1:0]),
      .b         (b_s[k][W-1:0]),
      .busy      (busy_s[k]),
      .done      (done_s[k]),
      .quotient  (w_q),
      .remainder (w_r),
      .div_zero  (dz_s[k])
    );

    assign q_s[k] = 32'(w_q);
    assign r_s[k] = 32'(w_r);
  end

  // Reference: plain integer division on sign-extended (or zero-extended) operands.
  function automatic void model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic [31:0] mask;
    longint ua, ub, sa, sb, qq, rr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    ua = longint'(a & mask);
    ub = longint'(b & mask);
    if (ub == 0) begin
      q  = mask;
      r  = a & mask;
      dz = 1'b1;
      return;
    end
    dz = 1'b0;
    if (sgn) begin
      sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      qq = sa / sb;
      rr = sa % sb;
    end else begin
      qq = ua / ub;
      rr = ua % ub;
    end
    q = 32'(qq) & mask;
    r = 32'(rr) & mask;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_8000;
      4: return 32'hFFFF_8000;
      5: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called on a falling edge; raises start for one cycle on instance 0 and waits for done.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    sop_s[0]   = sgn;
    a_s[0]     = a;
    b_s[0]     = b;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    sop_s[0]   = ~sgn;
    a_s[0]     = $urandom;
    b_s[0]     = $urandom;
    lat        = 1;
    busy_ok    = 1'b1;
    while (done_s[0] !== 1'b1 && lat < 60) begin
      if (busy_s[0] !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy_s[0] !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy_s[0], done_s[0], dz_s[0]} !== 3'b000 || q_s[0] !== 32'h0 || r_s[0] !== 32'h0) begin
      failed++;
      $display("FAIL reset_held: got busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
               busy_s[0], done_s[0], dz_s[0], q_s[0], r_s[0]);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests_run++;
      if ({busy_s[k], done_s[k], dz_s[k]} !== 3'b000) begin
        failed++;
        $display("FAIL reset_flags[%0d]: got %b expected 000", k, {busy_s[k], done_s[k], dz_s[k]});
      end
      tests_run++;
      if (q_s[k] !== 32'h0 || r_s[k] !== 32'h0) begin
        failed++;
        $display("FAIL reset_results[%0d]: got q=%h r=%h expected 0/0", k, q_s[k], r_s[k]);
      end
    end
  endtask

  task automatic test_directed();
    bit          dsg [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] da  [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h1234};
    logic [31:0] db  [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] eq  [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] er  [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 32'h1234, 32'h1234};
    logic        ez  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    bit bok;
    for (int i = 0; i < 7; i++) begin
      do_op(dsg[i], da[i], db[i], lat, bok);
      tests_run++;
      if (q_s[0] !== eq[i]) begin
        failed++;
        $display("FAIL directed[%0d] quotient: got %h expected %h", i, q_s[0], eq[i]);
      end
      tests_run++;
      if (r_s[0] !== er[i]) begin
        failed++;
        $display("FAIL directed[%0d] remainder: got %h expected %h", i, r_s[0], er[i]);
      end
      tests_run++;
      if (dz_s[0] !== ez[i]) begin
        failed++;
        $display("FAIL directed[%0d] div_zero: got %b expected %b", i, dz_s[0], ez[i]);
      end
      tests_run++;
      if (lat != 11) begin
        failed++;
        $display("FAIL directed[%0d] latency: got %0d expected 11", i, lat);
      end
      tests_run++;
      if (!bok) begin
        failed++;
        $display("FAIL directed[%0d] busy_window: got irregular busy, expected high in cycles 1-10 only", i);
      end
    end
  endtask

  task automatic test_abort();
    int lat, seen;
    bit bok;
    do_op(1'b0, 32'd20, 32'd3, lat, bok);
    a_s[0] = 32'd1000; b_s[0] = 32'd7; sop_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    tests_run++;
    if (busy_s[0] !== 1'b0) begin
      failed++;
      $display("FAIL abort_busy: got %b expected 0", busy_s[0]);
    end
    seen = 0;
    repeat (15) begin
      if (done_s[0] !== 1'b0) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin
      failed++;
      $display("FAIL abort_no_done: got %0d done cycles expected 0", seen);
    end
    tests_run++;
    if (q_s[0] !== 32'd6 || r_s[0] !== 32'd2 || dz_s[0] !== 1'b0) begin
      failed++;
      $display("FAIL abort_hold: got q=%h r=%h dz=%b expected 6/2/0", q_s[0], r_s[0], dz_s[0]);
    end
  endtask

  task automatic test_ignored_start();
    int lat, seen;
    a_s[0] = 32'd9; b_s[0] = 32'd3; sop_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    a_s[0] = 32'd50; b_s[0] = 32'd5; sop_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    lat = 4;
    while (done_s[0] !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != 11) begin
      failed++;
      $display("FAIL busy_start_latency: got %0d expected 11", lat);
    end
    tests_run++;
    if (q_s[0] !== 32'd3 || r_s[0] !== 32'd0 || dz_s[0] !== 1'b0) begin
      failed++;
      $display("FAIL busy_start_result: got q=%h r=%h dz=%b expected 3/0/0", q_s[0], r_s[0], dz_s[0]);
    end
    @(negedge clk);
    seen = 0;
    repeat (14) begin
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin
      failed++;
      $display("FAIL busy_start_ignored: got %0d active cycles expected 0", seen);
    end
    a_s[0] = 32'd8; b_s[0] = 32'd2; start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    seen = 0;
    repeat (14) begin
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0 || q_s[0] !== 32'd3) begin
      failed++;
      $display("FAIL abort_beats_start: got %0d active cycles q=%h expected 0 and 3", seen, q_s[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen;
    bit bok;
    do_op(1'b1, 32'd5, 32'd0, lat, bok);
    tests_run++;
    if (q_s[0] !== 32'hFFFF_FFFF || r_s[0] !== 32'd5 || dz_s[0] !== 1'b1 || lat != 11) begin
      failed++;
      $display("FAIL div_zero_small: got q=%h r=%h dz=%b lat=%0d expected ffffffff/5/1/11",
               q_s[0], r_s[0], dz_s[0], lat);
    end
    a_s[0] = 32'd500; b_s[0] = 32'd3; sop_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_s[0], done_s[0], dz_s[0]} !== 3'b000 || q_s[0] !== 32'h0 || r_s[0] !== 32'h0) begin
      failed++;
      $display("FAIL reset_mid_run: got busy=%b done=%b dz=%b q=%h r=%h expected all zero",
               busy_s[0], done_s[0], dz_s[0], q_s[0], r_s[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin
      failed++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok, sgn;
    logic [31:0] a, b, eq, er;
    logic ez;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = rand_op();
      b = rand_op();
      model(32, sgn, a, b, eq, er, ez);
      do_op(sgn, a, b, lat, bok);
      tests_run++;
      if (q_s[0] !== eq || r_s[0] !== er || dz_s[0] !== ez) begin
        failed++;
        $display("FAIL b2b[%0d] %s %h/%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                 i, sgn ? "signed" : "unsigned", a, b, q_s[0], r_s[0], dz_s[0], eq, er, ez);
      end
      tests_run++;
      if (lat != 11 || !bok) begin
        failed++;
        $display("FAIL b2b[%0d] timing: got lat=%0d busy_ok=%b expected 11/1", i, lat, bok);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ea [NI];
    logic [31:0] eb [NI];
    bit          es [NI];
    int          lat  [NI];
    int          dcnt [NI];
    logic [31:0] eq, er;
    logic        ez;
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < NI; k++) begin
        es[k] = 1'($urandom_range(0, 1));
        ea[k] = rand_op();
        eb[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : rand_op();
        sop_s[k] = es[k]; a_s[k] = ea[k]; b_s[k] = eb[k]; start_s[k] = 1'b1;
        lat[k] = 0; dcnt[k] = 0;
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        start_s[k] = 1'b0;
        a_s[k] = $urandom;
        b_s[k] = $urandom;
      end
      for (int c = 1; c <= 38; c++) begin
        for (int k = 0; k < NI; k++) begin
          if (done_s[k] === 1'b1) begin
            dcnt[k]++;
            if (lat[k] == 0) lat[k] = c;
          end
        end
        @(negedge clk);
      end
      for (int k = 0; k < NI; k++) begin
        model(cfg_w(k), es[k], ea[k], eb[k], eq, er, ez);
        tests_run++;
        if (q_s[k] !== eq || r_s[k] !== er || dz_s[k] !== ez) begin
          failed++;
          $display("FAIL sweep[%0d] cfg W%0d/S%0d %s %h/%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                   it, cfg_w(k), cfg_s(k), es[k] ? "signed" : "unsigned", ea[k], eb[k],
                   q_s[k], r_s[k], dz_s[k], eq, er, ez);
        end
        tests_run++;
        if (lat[k] != cfg_w(k) / cfg_s(k) + 3 || dcnt[k] != 1) begin
          failed++;
          $display("FAIL sweep[%0d] cfg W%0d/S%0d timing: got lat=%0d dones=%0d expected lat=%0d dones=1",
                   it, cfg_w(k), cfg_s(k), lat[k], dcnt[k], cfg_w(k) / cfg_s(k) + 3);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0;
      sop_s[k]   = 1'b0;
      abort_s[k] = 1'b0;
      a_s[k]     = 32'h0;
      b_s[k]     = 32'h0;
    end
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_abort();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
